right_rotation_seq: RTL and testbench
=====================================

RIGHT_ROTATION_SEQ -- requirements
Module: right_rotation_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 The block SHALL have parameter SW, default 3, amount-field width, equal to log2(WIDTH).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-005 The block SHALL have port start, input, 1, operation request, sampled on the rising edge of clk.
REQ-006 The block SHALL have port din, input, WIDTH, operand, captured when start is accepted.
REQ-007 The block SHALL have port s, input, SW, right-rotation amount, captured when start is accepted.
REQ-008 The block SHALL have port busy, output, 1, high while an operation is in progress (any state other than IDLE).
REQ-009 The block SHALL have port done, output, 1, a one-cycle completion strobe.
REQ-010 The block SHALL have port dout, output, WIDTH, working/result register.

Function
REQ-011 The block SHALL implement a registered FSM with three states: IDLE, ROT and DONE.
REQ-012 The block SHALL perform rotation iteratively with a single-position right-rotate datapath: per ROT cycle, dout <= {dout[0], dout[WIDTH-1:1]}.
REQ-013 In IDLE, start=1 SHALL be accepted, and on that edge: dout <= din, cnt <= s, then state <= ROT if s != 0, else DONE.
REQ-014 In ROT, each edge SHALL rotate dout by one position and decrement cnt; when cnt == 1 on that edge, the next state SHALL be DONE.
REQ-015 The block SHALL spend exactly s cycles in ROT; the final dout SHALL equal din rotated right by s positions, modulo WIDTH.
REQ-016 In DONE: done=1 for exactly one cycle, dout holds its value, and the next state SHALL be IDLE unconditionally.
REQ-017 Latency: counting the accepting edge as edge 1, done SHALL be high in the cycle following edge s+1.
REQ-018 For s=0, done SHALL be high in the cycle following the accepting edge, with dout = din.
REQ-019 busy SHALL be 1 in ROT and DONE and 0 in IDLE; busy SHALL be a registered-state decode with no combinational path from start.
REQ-020 start SHALL be ignored while busy=1, including in DONE; captured din, s and dout SHALL be unaffected.
REQ-021 Back-to-back operation: the earliest a new start can be accepted is the edge leaving IDLE again, i.e. one cycle after done.
REQ-022 In IDLE without start, dout SHALL hold the last result indefinitely.
REQ-023 The cnt register SHALL be SW bits wide; no wrap-around SHALL be possible because the decrement never occurs at cnt == 0.
REQ-024 din and s SHALL only be sampled at acceptance; changes to them during ROT SHALL have no effect.

Reset
REQ-025 When rst=1, independent of clk, the block SHALL force state=IDLE, cnt=0, dout=0, busy=0 and done=0.
REQ-026 rst asserted mid-operation (ROT or DONE) SHALL abort immediately, with no done pulse produced for the aborted operation.
REQ-027 On the first rising edge after rst deasserts, a start SHALL be accepted normally.

Verification
REQ-028 Reset: assert rst with no clock edge -> busy=0, done=0, dout=00000000 immediately.
REQ-029 Basic: din=10000001, s=1, start pulse -> busy for 2 cycles, done in the cycle after edge 2, dout=11000000.
REQ-030 Max amount: din=11111110, s=7 -> 7 ROT cycles, done after edge 8, dout=11111101; intermediate dout after edge 2 = 01111111.
REQ-031 Zero amount: din=10100101, s=0 -> done after edge 1, dout=10100101, no ROT cycle observed.
REQ-032 Busy rejection: start again with din=00001111, s=3 during ROT of the REQ-030 operation -> ignored; result is still 11111101 and exactly one done pulse occurs.
REQ-033 Abort: assert rst during the 3rd ROT cycle of an s=5 operation -> dout=00000000, busy=0 at once, and no done pulse; a following start with din=10000001, s=2 yields dout=01100000.

Source files
------------

// File: rtl/right_rotation_seq.sv
// right_rotation_seq: rotates an operand right by a variable amount, one
// position per clock. The operation has three phases: IDLE, then ROT
// (s cycles), then DONE (one cycle with the done strobe high). dout is
// both the working register and the result register.
//
// Request semantics: start is a request, and !busy is its ready. A request
// is accepted on a rising clk edge where start=1 and the FSM is in IDLE.
// Only on that edge are din and s sampled. A start seen while busy is
// dropped, not queued, so the requester must hold it or raise it again
// once busy falls. There is no backpressure on done. It is a one-cycle
// strobe, and dout stays valid until the next accepted request.
module right_rotation_seq #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SW-1:0]    s,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROT  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] dout_q, dout_d;

  // State, count and data registers; async reset aborts any operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state and datapath selection; every register holds by default.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dout_d  = din;
          cnt_d   = s;
          // A zero amount skips ROT entirely, so done follows acceptance.
          state_d = (s != '0) ? ROT : DONE;
        end
      end
      ROT: begin
        // ROT is only entered with cnt != 0, so this never wraps.
        dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        // Encoding 2'd3 is unreachable, but recover to IDLE if it appears.
        state_d = IDLE;
      end
    endcase
  end

  // Status outputs decode the registered state only, with no path from start.
  always_comb begin
    busy      = (state_q != IDLE);
    done      = (state_q == DONE);
    dout      = dout_q;
    state_dbg = state_q;
  end

  // The done strobe never lasts longer than one cycle.
  property p_done_single;
    @(posedge clk) disable iff (rst) done |=> !done;
  endproperty
  a_done_single: assert property (p_done_single);

  // The counter is never zero while rotating.
  property p_cnt_nonzero_in_rot;
    @(posedge clk) disable iff (rst) (state_q == ROT) |-> (cnt_q != '0);
  endproperty
  a_cnt_nonzero_in_rot: assert property (p_cnt_nonzero_in_rot);

  // DONE always returns to IDLE.
  property p_done_to_idle;
    @(posedge clk) disable iff (rst) (state_q == DONE) |=> (state_q == IDLE);
  endproperty
  a_done_to_idle: assert property (p_done_to_idle);

endmodule

// File: tb/tb_right_rotation_seq.sv
// Testbench for right_rotation_seq.
// It starts with a table of directed operations, each with a
// hand-computed result. Hand-written sequences then cover reset,
// intermediate data, requests made while busy, and an abort.
module tb_right_rotation_seq;

  localparam int W  = 8;
  localparam int SW = 3;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  din;
  logic [SW-1:0] s;
  logic          busy;
  logic          done;
  logic [W-1:0]  dout;
  logic [1:0]    state_dbg;

  always #5 clk = ~clk;

  right_rotation_seq #(.WIDTH(W), .SW(SW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .din       (din),
    .s         (s),
    .busy      (busy),
    .done      (done),
    .dout      (dout),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  int done_pulses = 0;

  // Count done strobes, sampling away from the active edge.
  always @(negedge clk) begin
    if (done === 1'b1) done_pulses = done_pulses + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] amt;
    logic [W-1:0]  res;
  } vec_t;

  // ---------------- driver tasks ----------------
  // Call this at a negedge while the DUT is idle. It requests an operation,
  // waits (with a bound) for done, and checks latency, result and the
  // one-cycle strobe. It returns at the negedge after done, when the DUT
  // is idle again.
  task automatic run_op(input logic [W-1:0] d, input logic [SW-1:0] amt,
                        input logic [W-1:0] res, input string name);
    int n;
    logic [W-1:0] e;
    din   = d;
    s     = amt;
    start = 1'b1;
    exp_q.push_back(res);
    @(negedge clk);
    start = 1'b0;
    n = 1;
    check({name, "_busy_after_accept"}, {31'd0, busy}, 32'd1);
    while (done !== 1'b1 && n < 40) begin
      @(negedge clk);
      n = n + 1;
    end
    check({name, "_latency"}, n, int'(amt) + 1);
    e = exp_q.pop_front();
    check({name, "_dout"}, {24'd0, dout}, {24'd0, e});
    @(negedge clk);
    check({name, "_done_one_cycle"}, {31'd0, done}, 32'd0);
    check({name, "_idle_after"}, {31'd0, busy}, 32'd0);
    check({name, "_dout_hold"}, {24'd0, dout}, {24'd0, e});
  endtask

  vec_t vecs[9];

  initial begin
    int pulses0;
    vecs[0] = '{8'b10000001, 3'd1, 8'b11000000};
    vecs[1] = '{8'b11111110, 3'd7, 8'b11111101};
    vecs[2] = '{8'b10100101, 3'd0, 8'b10100101};
    vecs[3] = '{8'b00000001, 3'd1, 8'b10000000};
    vecs[4] = '{8'b10110000, 3'd4, 8'b00001011};
    vecs[5] = '{8'b00010010, 3'd3, 8'b01000010};
    vecs[6] = '{8'b11001010, 3'd2, 8'b10110010};
    vecs[7] = '{8'b01111111, 3'd6, 8'b11111101};
    vecs[8] = '{8'b00000000, 3'd5, 8'b00000000};

    rst = 1'b1; start = 1'b0; din = '0; s = '0;
    // Reset acts with no clock edge yet (the first posedge is at t=5).
    #2;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_dout", {24'd0, dout}, 32'd0);
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven operations, issued as soon as the DUT is idle again.
    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].d, vecs[i].amt, vecs[i].res, $sformatf("vec%0d", i));
    end

    // Max amount with an intermediate check, plus requests made while busy.
    pulses0 = done_pulses;
    din = 8'b11111110; s = 3'd7; start = 1'b1;
    @(negedge clk);                       // after edge 1 (accept)
    check("max_state_rot", {30'd0, state_dbg}, 32'd1);
    din = 8'b00001111; s = 3'd3;          // start still high: must be ignored
    @(negedge clk);                       // after edge 2
    check("max_intermediate", {24'd0, dout}, {24'd0, 8'b01111111});
    for (int k = 3; k <= 8; k++) begin
      @(negedge clk);
      if (k == 8) check("max_done_edge8", {31'd0, done}, 32'd1);
      else        check($sformatf("max_no_done_edge%0d", k), {31'd0, done}, 32'd0);
    end
    check("max_result", {24'd0, dout}, {24'd0, 8'b11111101});
    // start is still high during DONE, so the edge leaving DONE must ignore it.
    @(negedge clk);
    check("max_idle_after_done", {31'd0, busy}, 32'd0);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("max_hold_idle", {24'd0, dout}, {24'd0, 8'b11111101});
    check("max_single_done", done_pulses - pulses0, 1);

    // Abort during the 3rd ROT cycle of an s=5 operation.
    din = 8'b11100000; s = 3'd5; start = 1'b1;
    @(negedge clk);                       // after edge 1
    start = 1'b0;
    din = 8'b01010101; s = 3'd1;          // changes during ROT have no effect
    @(negedge clk);                       // after edge 2
    @(negedge clk);                       // after edge 3: 3rd ROT cycle
    check("abort_pre_busy", {31'd0, busy}, 32'd1);
    pulses0 = done_pulses;
    rst = 1'b1;
    #1;
    check("abort_dout", {24'd0, dout}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Start on the first edge after reset is released.
    run_op(8'b10000001, 3'd2, 8'b01100000, "post_abort");
    check("abort_no_extra_done", done_pulses - pulses0, 1);

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
